// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencing controller.
package vend_pkg;

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'd0;
    localparam coin_t COIN_ONE  = 2'd1;
    localparam coin_t COIN_TWO  = 2'd2;
    localparam coin_t COIN_BAD  = 2'd3;

    localparam int TMR_W = 16;

    // Credit value of a coin event; invalid and empty events are worth nothing.
    function automatic logic [1:0] coin_value(input coin_t coin);
        case (coin)
            COIN_ONE: return 2'd1;
            COIN_TWO: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_seq_ctrl_if.sv
// Coin, selection and actuator handshake bundle of the vending controller.
interface vend_seq_ctrl_if
    import vend_pkg::*;
#(
    parameter int N_PROD  = 4,
    parameter int PRICE_W = 4
);
    localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    coin_t                     coin;
    logic                      sel_valid;
    logic [ID_W-1:0]           sel_id;
    logic                      cancel;
    logic [N_PROD*PRICE_W-1:0] price_cfg;
    logic                      disp_req;
    logic [ID_W-1:0]           disp_id;
    logic                      disp_done;
    logic                      chg_req;
    logic                      chg_ack;
    logic                      coin_reject;
    logic                      sold;
    logic [PRICE_W-1:0]        credit;
    logic                      busy;

    modport master (
        output coin, sel_valid, sel_id, cancel, price_cfg, disp_done, chg_ack,
        input  disp_req, disp_id, chg_req, coin_reject, sold, credit, busy
    );

    modport slave (
        input  coin, sel_valid, sel_id, cancel, price_cfg, disp_done, chg_ack,
        output disp_req, disp_id, chg_req, coin_reject, sold, credit, busy
    );

endinterface

// File: rtl/vend_idle_timer.sv
// Inactivity counter: clears on demand, counts while enabled, holds at TIMEOUT.
module vend_idle_timer
    import vend_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == TMR_W'(TIMEOUT));

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: credit accumulation, price check, dispense and change
// handshakes, with refund on cancel or inactivity.
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int N_PROD  = 4,
    parameter int PRICE_W = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            rst,
    vend_seq_ctrl_if.slave  bus
);

    localparam int                 ID_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam logic [PRICE_W-1:0] CREDIT_MAX = '1;

    state_t             r_state, w_state_nxt;
    logic [PRICE_W-1:0] r_credit, w_credit_nxt;
    logic [ID_W-1:0]    r_disp_id, w_disp_id_nxt;
    logic               r_coin_reject, w_coin_reject_nxt;
    logic               r_sold, w_sold_nxt;
    logic               r_disp_req, r_chg_req, r_busy;
    logic               w_tmr_clear, w_tmr_expired;
    logic [PRICE_W-1:0] w_price;
    logic [1:0]         w_coin_val;
    logic [PRICE_W:0]   w_coin_sum;
    logic               w_coin_fits, w_sel_ok;

    vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_tmr_clear),
        .i_en      (r_state == CREDIT),
        .o_expired (w_tmr_expired)
    );

    // Out-of-range ids (non power-of-two N_PROD) read as a disabled product.
    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.sel_id == ID_W'(i)) begin
                w_price = bus.price_cfg[i*PRICE_W +: PRICE_W];
            end
        end
    end

    assign w_coin_val  = coin_value(bus.coin);
    assign w_coin_sum  = {1'b0, r_credit} + (PRICE_W+1)'(w_coin_val);
    assign w_coin_fits = (w_coin_val != 2'd0) && (w_coin_sum <= {1'b0, CREDIT_MAX});
    assign w_sel_ok    = bus.sel_valid && (w_price != '0) && (r_credit >= w_price);

    // Any coin is returned unless a branch below explicitly banks it.
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_disp_id_nxt     = r_disp_id;
        w_coin_reject_nxt = (bus.coin != COIN_NONE);
        w_sold_nxt        = 1'b0;
        w_tmr_clear       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_coin_fits) begin
                    w_credit_nxt      = w_coin_sum[PRICE_W-1:0];
                    w_coin_reject_nxt = 1'b0;
                    w_tmr_clear       = 1'b1;
                    w_state_nxt       = CREDIT;
                end
            end
            CREDIT: begin
                if (w_tmr_expired || bus.cancel) begin
                    w_state_nxt = CHANGE;
                end else if (w_sel_ok) begin
                    w_credit_nxt  = r_credit - w_price;
                    w_disp_id_nxt = bus.sel_id;
                    w_state_nxt   = DISPENSE;
                end else if (w_coin_fits) begin
                    w_credit_nxt      = w_coin_sum[PRICE_W-1:0];
                    w_coin_reject_nxt = 1'b0;
                    w_tmr_clear       = 1'b1;
                end
            end
            DISPENSE: begin
                if (bus.disp_done) begin
                    w_sold_nxt  = 1'b1;
                    w_state_nxt = (r_credit != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (bus.chg_ack && (r_credit != '0)) begin
                    w_credit_nxt = r_credit - 1'b1;
                    if (r_credit == PRICE_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_credit == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_disp_id     <= '0;
            r_coin_reject <= 1'b0;
            r_sold        <= 1'b0;
            r_disp_req    <= 1'b0;
            r_chg_req     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_disp_id     <= w_disp_id_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sold        <= w_sold_nxt;
            r_disp_req    <= (w_state_nxt == DISPENSE);
            r_chg_req     <= (w_state_nxt == CHANGE);
            r_busy        <= (w_state_nxt == DISPENSE) || (w_state_nxt == CHANGE);
        end
    end

    assign bus.disp_req    = r_disp_req;
    assign bus.disp_id     = r_disp_id;
    assign bus.chg_req     = r_chg_req;
    assign bus.coin_reject = r_coin_reject;
    assign bus.sold        = r_sold;
    assign bus.credit      = r_credit;
    assign bus.busy        = r_busy;

endmodule
